actmem_gather: RTL and testbench



---
 rtl/actmem_pkg.sv | 21 ++
 rtl/actmem_bank.sv | 44 ++++
 rtl/actmem_gather.sv | 120 ++++++++++++
 tb/tb_actmem_gather.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/actmem_pkg.sv
// Shared types and helpers for the double-buffered activation gather memory.
// Buffer sets cycle EMPTY -> FILLING -> FULL -> READING -> EMPTY.
package actmem_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    READING = 2'd3
  } set_state_t;

  // Row-address width; a single-row bank still keeps a 1-bit address.
  function automatic int log_pbyz(input int p, input int z);
    return (p == z) ? 1 : $clog2(p / z);
  endfunction

  function automatic int lane_lsb(input int lane, input int lane_width);
    return lane * lane_width;
  endfunction

endpackage

// File: rtl/actmem_bank.sv
// One lane bank: simple dual-port RAM, one write and one registered read port.
// Read data appears the cycle after rd_en and holds until the next rd_en.
module actmem_bank #(
  parameter int depth  = 4,
  parameter int addr_w = 2,
  parameter int width  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [addr_w-1:0] wr_addr,
  input  logic [width-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [addr_w-1:0] rd_addr,
  output logic [width-1:0]  rd_data
);

  logic [width-1:0] mem [depth];

  if (depth == 1) begin : g_single
    // Only one row exists, so the addresses carry no information.
    logic unused_addr;
    assign unused_addr = ^{wr_addr, rd_addr};

    always_ff @(posedge clk) begin
      if (wr_en) mem[0] <= wr_data;
    end

    always_ff @(posedge clk) begin
      if (reset)      rd_data <= '0;
      else if (rd_en) rd_data <= mem[0];
    end
  end else begin : g_multi
    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
      if (reset)      rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/actmem_gather.sv
// Double-buffered activation memory: one set fills row by row while the other
// is gathered z lanes at a time, with 1-cycle read latency.
module actmem_gather
  import actmem_pkg::*;
#(
  parameter  int p     = 32,
  parameter  int z     = 8,
  parameter  int width = 16,
  localparam int log_p = $clog2(p)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_valid,
  input  logic [width*z-1:0] wr_data,
  output logic               wr_ready,
  input  logic               rd_valid,
  input  logic               rd_last,
  input  logic [log_p*z-1:0] memory_index_package,
  output logic               rd_ready,
  output logic [width*z-1:0] rd_data,
  output logic               rd_data_valid,
  output logic               lane_err
);

  localparam int depth = p / z;
  localparam int row_w = log_pbyz(p, z);
  localparam int log_z = $clog2(z);
  localparam logic [row_w-1:0] last_row = row_w'(depth - 1);

  set_state_t       state [2];
  logic             wr_set;
  logic             rd_set;
  logic             rd_sel;
  logic [row_w-1:0] wr_row;
  logic             wr_fire;
  logic             rd_fire;
  logic [row_w-1:0] rd_row [z];
  logic [z-1:0]     bank_bad;
  logic [width-1:0] bank_q [2][z];

  assign wr_ready = (state[wr_set] == EMPTY) || (state[wr_set] == FILLING);
  assign rd_ready = (state[rd_set] == FULL)  || (state[rd_set] == READING);
  assign wr_fire  = wr_valid && wr_ready;
  assign rd_fire  = rd_valid && rd_ready;

  for (genvar i = 0; i < z; i++) begin : g_lane
    logic [log_p-1:0] idx;
    assign idx = memory_index_package[lane_lsb(i, log_p) +: log_p];

    if (p == z) begin : g_flat
      assign rd_row[i] = '0;
    end else begin : g_rows
      assign rd_row[i] = idx[log_p-1:log_z];
    end

    // The interleaver should always steer lane i to bank i; anything else is a fault.
    assign bank_bad[i] = (idx[log_z-1:0] != log_z'(i));

    assign rd_data[lane_lsb(i, width) +: width] = bank_q[rd_sel][i];
  end

  for (genvar s = 0; s < 2; s++) begin : g_set
    for (genvar i = 0; i < z; i++) begin : g_bank
      actmem_bank #(
        .depth  (depth),
        .addr_w (row_w),
        .width  (width)
      ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_fire && (wr_set == 1'(s))),
        .wr_addr (wr_row),
        .wr_data (wr_data[lane_lsb(i, width) +: width]),
        .rd_en   (rd_fire && (rd_set == 1'(s))),
        .rd_addr (rd_row[i]),
        .rd_data (bank_q[s][i])
      );
    end
  end

  // Write and read always target different sets when both fire, so the two
  // state updates below never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      state[0]      <= EMPTY;
      state[1]      <= EMPTY;
      wr_set        <= 1'b0;
      rd_set        <= 1'b0;
      rd_sel        <= 1'b0;
      wr_row        <= '0;
      rd_data_valid <= 1'b0;
      lane_err      <= 1'b0;
    end else begin
      rd_data_valid <= rd_fire;

      if (wr_fire) begin
        if (wr_row == last_row) begin
          state[wr_set] <= FULL;
          wr_row        <= '0;
          wr_set        <= ~wr_set;
        end else begin
          state[wr_set] <= FILLING;
          wr_row        <= wr_row + 1'b1;
        end
      end

      if (rd_fire) begin
        rd_sel <= rd_set;
        if (|bank_bad) lane_err <= 1'b1;
        if (rd_last) begin
          state[rd_set] <= EMPTY;
          rd_set        <= ~rd_set;
        end else begin
          state[rd_set] <= READING;
        end
      end
    end
  end

endmodule

// File: tb/tb_actmem_gather.sv
// Directed bench for actmem_gather: a p=32/z=8 instance plus a p==z=8 instance.
module tb_actmem_gather;
  localparam int W  = 16;
  localparam int Z  = 8;
  localparam int LP = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic           wr_valid, rd_valid, rd_last;
  logic [W*Z-1:0] wr_data, rd_data;
  logic [LP*Z-1:0] idx;
  logic           wr_ready, rd_ready, rd_data_valid, lane_err;

  logic           s_wr_valid, s_rd_valid, s_rd_last;
  logic [W*Z-1:0] s_wr_data, s_rd_data;
  logic [3*Z-1:0] s_idx;
  logic           s_wr_ready, s_rd_ready, s_rd_data_valid, s_lane_err;

  int vectors = 0;
  int miscompares = 0;

  actmem_gather #(.p(32), .z(8), .width(16)) u_dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_last(rd_last), .memory_index_package(idx), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .lane_err(lane_err)
  );

  actmem_gather #(.p(8), .z(8), .width(16)) u_small (
    .clk(clk), .reset(reset), .wr_valid(s_wr_valid), .wr_data(s_wr_data), .wr_ready(s_wr_ready),
    .rd_valid(s_rd_valid), .rd_last(s_rd_last), .memory_index_package(s_idx), .rd_ready(s_rd_ready),
    .rd_data(s_rd_data), .rd_data_valid(s_rd_data_valid), .lane_err(s_lane_err)
  );

  // Lane i of row r holds base + i*16 + r.
  function automatic logic [W*Z-1:0] row_vec(input int base, input int row);
    logic [W*Z-1:0] v;
    for (int i = 0; i < Z; i++) v[i*W +: W] = 16'(base + i*16 + row);
    return v;
  endfunction

  function automatic logic [LP*Z-1:0] ident_idx(input int row);
    logic [LP*Z-1:0] v;
    for (int i = 0; i < Z; i++) v[i*LP +: LP] = 5'(row*8 + i);
    return v;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_valid = 1'b0; rd_valid = 1'b0; rd_last = 1'b0;
    s_wr_valid = 1'b0; s_rd_valid = 1'b0; s_rd_last = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic fill(input int base);
    for (int r = 0; r < 4; r++) begin
      wr_valid = 1'b1;
      wr_data  = row_vec(base, r);
      step();
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL reset wr_ready: got %b want 1", wr_ready); end
    vectors++; if (rd_ready !== 1'b0) begin miscompares++; $display("FAIL reset rd_ready: got %b want 0", rd_ready); end
    vectors++; if (rd_data !== '0) begin miscompares++; $display("FAIL reset rd_data: got %h want 0", rd_data); end
    vectors++; if (rd_data_valid !== 1'b0) begin miscompares++; $display("FAIL reset rd_data_valid: got %b want 0", rd_data_valid); end
    vectors++; if (lane_err !== 1'b0) begin miscompares++; $display("FAIL reset lane_err: got %b want 0", lane_err); end
    vectors++; if (s_wr_ready !== 1'b1 || s_rd_ready !== 1'b0) begin miscompares++; $display("FAIL reset small ready: got wr=%b rd=%b want wr=1 rd=0", s_wr_ready, s_rd_ready); end
  endtask

  task automatic test_fill_read();
    do_reset();
    fill('h000);
    vectors++; if (rd_ready !== 1'b1) begin miscompares++; $display("FAIL fill_read rd_ready after fill: got %b want 1", rd_ready); end
    vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL fill_read wr_ready after fill: got %b want 1", wr_ready); end
    for (int r = 0; r < 4; r++) begin
      rd_valid = 1'b1; idx = ident_idx(r); rd_last = (r == 3);
      step();
      vectors++; if (rd_data_valid !== 1'b1) begin miscompares++; $display("FAIL fill_read valid row%0d: got %b want 1", r, rd_data_valid); end
      vectors++; if (rd_data !== row_vec('h000, r)) begin miscompares++; $display("FAIL fill_read data row%0d: got %h want %h", r, rd_data, row_vec('h000, r)); end
      vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL fill_read wr_ready row%0d: got %b want 1", r, wr_ready); end
    end
    rd_valid = 1'b0; rd_last = 1'b0;
    step();
    vectors++; if (rd_data_valid !== 1'b0) begin miscompares++; $display("FAIL fill_read valid idle: got %b want 0", rd_data_valid); end
    vectors++; if (rd_data !== row_vec('h000, 3)) begin miscompares++; $display("FAIL fill_read hold: got %h want %h", rd_data, row_vec('h000, 3)); end
    vectors++; if (rd_ready !== 1'b0) begin miscompares++; $display("FAIL fill_read released rd_ready: got %b want 0", rd_ready); end
  endtask

  task automatic test_ping_pong();
    do_reset();
    fill('h100);
    for (int r = 0; r < 4; r++) begin
      wr_valid = 1'b1; wr_data = row_vec('h200, r);
      rd_valid = (r < 3); idx = ident_idx(r); rd_last = 1'b0;
      step();
      if (r < 3) begin
        vectors++; if (rd_data_valid !== 1'b1 || rd_data !== row_vec('h100, r)) begin miscompares++; $display("FAIL ping_pong overlap row%0d: got v=%b %h want v=1 %h", r, rd_data_valid, rd_data, row_vec('h100, r)); end
      end
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL ping_pong both busy wr_ready: got %b want 0", wr_ready); end
    vectors++; if (rd_ready !== 1'b1) begin miscompares++; $display("FAIL ping_pong both busy rd_ready: got %b want 1", rd_ready); end
    step();
    vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL ping_pong idle wr_ready: got %b want 0", wr_ready); end
    rd_valid = 1'b1; idx = ident_idx(3); rd_last = 1'b1;
    step();
    vectors++; if (rd_data !== row_vec('h100, 3)) begin miscompares++; $display("FAIL ping_pong last data: got %h want %h", rd_data, row_vec('h100, 3)); end
    vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL ping_pong release wr_ready: got %b want 1", wr_ready); end
    vectors++; if (rd_ready !== 1'b1) begin miscompares++; $display("FAIL ping_pong set1 rd_ready: got %b want 1", rd_ready); end
    for (int r = 0; r < 4; r++) begin
      rd_valid = 1'b1; idx = ident_idx(r); rd_last = (r == 3);
      step();
      vectors++; if (rd_data !== row_vec('h200, r)) begin miscompares++; $display("FAIL ping_pong set1 row%0d: got %h want %h", r, rd_data, row_vec('h200, r)); end
    end
    rd_valid = 1'b0; rd_last = 1'b0;
  endtask

  task automatic test_read_empty();
    for (int k = 0; k < 3; k++) begin
      rd_valid = 1'b1; idx = ident_idx(0); rd_last = (k == 2);
      step();
      vectors++; if (rd_data_valid !== 1'b0) begin miscompares++; $display("FAIL read_empty valid c%0d: got %b want 0", k, rd_data_valid); end
      vectors++; if (rd_data !== row_vec('h200, 3)) begin miscompares++; $display("FAIL read_empty hold c%0d: got %h want %h", k, rd_data, row_vec('h200, 3)); end
      vectors++; if (rd_ready !== 1'b0) begin miscompares++; $display("FAIL read_empty rd_ready c%0d: got %b want 0", k, rd_ready); end
    end
    rd_valid = 1'b0; rd_last = 1'b0;
    fill('h250);
    vectors++; if (rd_ready !== 1'b1) begin miscompares++; $display("FAIL read_empty refill rd_ready: got %b want 1", rd_ready); end
    rd_valid = 1'b1; idx = ident_idx(0); rd_last = 1'b1;
    step();
    rd_valid = 1'b0; rd_last = 1'b0;
    vectors++; if (rd_data !== row_vec('h250, 0)) begin miscompares++; $display("FAIL read_empty refill data: got %h want %h", rd_data, row_vec('h250, 0)); end
  endtask

  task automatic test_lane_mismatch();
    logic [LP*Z-1:0] bad;
    do_reset();
    fill('h300);
    vectors++; if (lane_err !== 1'b0) begin miscompares++; $display("FAIL lane_mismatch before: got %b want 0", lane_err); end
    bad = ident_idx(0);
    bad[3*LP +: LP] = 5'd5;
    rd_valid = 1'b1; idx = bad; rd_last = 1'b0;
    step();
    vectors++; if (lane_err !== 1'b1) begin miscompares++; $display("FAIL lane_mismatch flag: got %b want 1", lane_err); end
    vectors++; if (rd_data !== row_vec('h300, 0)) begin miscompares++; $display("FAIL lane_mismatch data: got %h want %h", rd_data, row_vec('h300, 0)); end
    idx = ident_idx(1); rd_last = 1'b1;
    step();
    rd_valid = 1'b0; rd_last = 1'b0;
    step();
    vectors++; if (lane_err !== 1'b1) begin miscompares++; $display("FAIL lane_mismatch sticky: got %b want 1", lane_err); end
    do_reset();
    vectors++; if (lane_err !== 1'b0) begin miscompares++; $display("FAIL lane_mismatch cleared: got %b want 0", lane_err); end
  endtask

  task automatic test_p_eq_z();
    do_reset();
    for (int i = 0; i < Z; i++) s_idx[i*3 +: 3] = 3'(i);
    s_wr_valid = 1'b1; s_wr_data = row_vec('h400, 0);
    step();
    s_wr_valid = 1'b0;
    vectors++; if (s_rd_ready !== 1'b1 || s_wr_ready !== 1'b1) begin miscompares++; $display("FAIL p_eq_z after write: got rd=%b wr=%b want rd=1 wr=1", s_rd_ready, s_wr_ready); end
    s_rd_valid = 1'b1; s_rd_last = 1'b1;
    step();
    s_rd_valid = 1'b0; s_rd_last = 1'b0;
    vectors++; if (s_rd_data_valid !== 1'b1 || s_rd_data !== row_vec('h400, 0)) begin miscompares++; $display("FAIL p_eq_z read: got v=%b %h want v=1 %h", s_rd_data_valid, s_rd_data, row_vec('h400, 0)); end
    vectors++; if (s_rd_ready !== 1'b0) begin miscompares++; $display("FAIL p_eq_z release rd_ready: got %b want 0", s_rd_ready); end
    s_wr_valid = 1'b1; s_wr_data = row_vec('h500, 0);
    step();
    s_wr_data = row_vec('h600, 0);
    step();
    s_wr_valid = 1'b0;
    vectors++; if (s_wr_ready !== 1'b0 || s_rd_ready !== 1'b1) begin miscompares++; $display("FAIL p_eq_z both full: got wr=%b rd=%b want wr=0 rd=1", s_wr_ready, s_rd_ready); end
    s_rd_valid = 1'b1; s_rd_last = 1'b1;
    step();
    s_rd_valid = 1'b0; s_rd_last = 1'b0;
    vectors++; if (s_rd_data !== row_vec('h500, 0)) begin miscompares++; $display("FAIL p_eq_z set1 data: got %h want %h", s_rd_data, row_vec('h500, 0)); end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    fill('h600);
    rd_valid = 1'b1; idx = ident_idx(0); rd_last = 1'b0;
    step();
    vectors++; if (rd_data_valid !== 1'b1 || rd_data !== row_vec('h600, 0)) begin miscompares++; $display("FAIL reset_mid pre-read: got v=%b %h want v=1 %h", rd_data_valid, rd_data, row_vec('h600, 0)); end
    idx = ident_idx(1); reset = 1'b1;
    step();
    reset = 1'b0; rd_valid = 1'b0;
    vectors++; if (wr_ready !== 1'b1 || rd_ready !== 1'b0) begin miscompares++; $display("FAIL reset_mid ready: got wr=%b rd=%b want wr=1 rd=0", wr_ready, rd_ready); end
    vectors++; if (rd_data !== '0 || rd_data_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mid data: got v=%b %h want v=0 0", rd_data_valid, rd_data); end
    vectors++; if (lane_err !== 1'b0) begin miscompares++; $display("FAIL reset_mid lane_err: got %b want 0", lane_err); end
    fill('h700);
    rd_valid = 1'b1; idx = ident_idx(2); rd_last = 1'b1;
    step();
    rd_valid = 1'b0; rd_last = 1'b0;
    vectors++; if (rd_data_valid !== 1'b1 || rd_data !== row_vec('h700, 2)) begin miscompares++; $display("FAIL reset_mid refill read: got v=%b %h want v=1 %h", rd_data_valid, rd_data, row_vec('h700, 2)); end
    vectors++; if (rd_ready !== 1'b0) begin miscompares++; $display("FAIL reset_mid release: got %b want 0", rd_ready); end
  endtask

  initial begin
    reset = 1'b1;
    wr_valid = 1'b0; rd_valid = 1'b0; rd_last = 1'b0;
    wr_data = '0; idx = '0;
    s_wr_valid = 1'b0; s_rd_valid = 1'b0; s_rd_last = 1'b0;
    s_wr_data = '0; s_idx = '0;
    step();
    test_reset();
    test_fill_read();
    test_ping_pong();
    test_read_empty();
    test_lane_mismatch();
    test_p_eq_z();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
